// File: rtl/i2c_slave_regport.sv
// I2C target with a register pointer: burst writes/reads into a host-side register bank,
// address/range NACKs and a split open-drain SDA (SDA_OE pulls the line low).
module i2c_slave_regport #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h23,
    parameter int         NUM_REGS    = 16,
    parameter bit         AUTO_INC    = 1'b1,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       SYSTEM_CLK,
    input  logic       RESET,
    input  logic       SCL,
    input  logic       SDA_IN,
    output logic       SDA_OE,
    output logic [7:0] RD_ADDR,
    input  logic [7:0] RD_DATA,
    output logic       WR_EN,
    output logic [7:0] WR_ADDR,
    output logic [7:0] WR_DATA,
    output logic       BUSY,
    output logic       XFER_DONE
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_t;

    localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

    logic [SYNC_STAGES-1:0] scl_sync_reg, sda_sync_reg;
    logic       scl_prev_reg, sda_prev_reg;
    state_t     state_reg, state_next;
    logic [3:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] rx_reg, rx_next;
    logic [6:0] tx_reg, tx_next;
    logic [7:0] ptr_reg, ptr_next;
    logic       rw_reg, rw_next;
    logic       mack_reg, mack_next;
    logic       sda_oe_reg, sda_oe_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    logic       wr_en_reg, wr_en_next;
    logic [7:0] wr_addr_reg, wr_addr_next;
    logic [7:0] wr_data_reg, wr_data_next;

    logic scl_s, sda_s, scl_rise, scl_fall, start_evt, stop_evt;
    logic bit_done, addr_match, rx_in_range, ptr_in_range;
    logic [7:0] ptr_inc, load_byte;

    assign scl_s     = scl_sync_reg[SYNC_STAGES-1];
    assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_reg;
    assign scl_fall  = ~scl_s & scl_prev_reg;
    assign start_evt = scl_s & scl_prev_reg & sda_prev_reg & ~sda_s;
    assign stop_evt  = scl_s & scl_prev_reg & ~sda_prev_reg & sda_s;

    assign bit_done     = (bit_cnt_reg == 4'd8);
    assign addr_match   = (rx_reg[7:1] == SLAVE_ADDR);
    assign rx_in_range  = ({1'b0, rx_reg} < NUM_REGS_W);
    assign ptr_in_range = ({1'b0, ptr_reg} < NUM_REGS_W);
    // The pointer sticks at 8'hFF instead of wrapping back into the valid range
    assign ptr_inc      = (ptr_reg == 8'hFF) ? ptr_reg : ptr_reg + 8'd1;
    assign load_byte    = ptr_in_range ? RD_DATA : 8'hFF;

    always_ff @(posedge SYSTEM_CLK) begin
        if (RESET) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            rx_reg       <= '0;
            tx_reg       <= '1;
            ptr_reg      <= '0;
            rw_reg       <= 1'b0;
            mack_reg     <= 1'b1;
            sda_oe_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
        end else begin
            scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], SCL};
            sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], SDA_IN};
            scl_prev_reg <= scl_s;
            sda_prev_reg <= sda_s;
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            rx_reg       <= rx_next;
            tx_reg       <= tx_next;
            ptr_reg      <= ptr_next;
            rw_reg       <= rw_next;
            mack_reg     <= mack_next;
            sda_oe_reg   <= sda_oe_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            wr_en_reg    <= wr_en_next;
            wr_addr_reg  <= wr_addr_next;
            wr_data_reg  <= wr_data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (start_evt) begin
            state_next = ADDR;
        end else if (stop_evt) begin
            state_next = IDLE;
        end else if (scl_fall) begin
            case (state_reg)
                ADDR:      if (bit_done) state_next = addr_match ? ADDR_ACK : WAIT_STOP;
                ADDR_ACK:  state_next = rw_reg ? RDATA : REG;
                REG:       if (bit_done) state_next = rx_in_range ? REG_ACK : WAIT_STOP;
                REG_ACK:   state_next = WDATA;
                WDATA:     if (bit_done) state_next = ptr_in_range ? WDATA_ACK : WAIT_STOP;
                WDATA_ACK: state_next = WDATA;
                RDATA:     if (bit_done) state_next = RDATA_ACK;
                RDATA_ACK: state_next = mack_reg ? WAIT_STOP : RDATA;
                default:   state_next = state_reg;
            endcase
        end
    end

    always_comb begin
        bit_cnt_next = bit_cnt_reg;
        rx_next      = rx_reg;
        tx_next      = tx_reg;
        ptr_next     = ptr_reg;
        rw_next      = rw_reg;
        mack_next    = mack_reg;
        sda_oe_next  = sda_oe_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        wr_en_next   = 1'b0;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;
        if (start_evt) begin
            bit_cnt_next = '0;
        end else if (stop_evt) begin
            sda_oe_next = 1'b0;
            busy_next   = 1'b0;
            done_next   = busy_reg;
        end else if (scl_rise) begin
            if ((state_reg == ADDR || state_reg == REG || state_reg == WDATA ||
                 state_reg == RDATA) && !bit_done)
                bit_cnt_next = bit_cnt_reg + 4'd1;
            if (state_reg == ADDR || state_reg == REG || state_reg == WDATA)
                rx_next = {rx_reg[6:0], sda_s};
            if (state_reg == RDATA_ACK)
                mack_next = sda_s;
        end else if (scl_fall) begin
            case (state_reg)
                ADDR: begin
                    sda_oe_next = 1'b0;
                    if (bit_done) begin
                        bit_cnt_next = '0;
                        sda_oe_next  = addr_match;
                        busy_next    = addr_match;
                        if (addr_match) rw_next = rx_reg[0];
                    end
                end
                ADDR_ACK: begin
                    bit_cnt_next = '0;
                    sda_oe_next  = 1'b0;
                    if (rw_reg) begin
                        tx_next     = load_byte[6:0];
                        sda_oe_next = ~load_byte[7];
                    end
                end
                REG: if (bit_done) begin
                    bit_cnt_next = '0;
                    sda_oe_next  = rx_in_range;
                    if (rx_in_range) ptr_next = rx_reg;
                end
                REG_ACK, WDATA_ACK, WAIT_STOP: begin
                    bit_cnt_next = '0;
                    sda_oe_next  = 1'b0;
                end
                WDATA: if (bit_done) begin
                    bit_cnt_next = '0;
                    sda_oe_next  = ptr_in_range;
                    if (ptr_in_range) begin
                        wr_en_next   = 1'b1;
                        wr_addr_next = ptr_reg;
                        wr_data_next = rx_reg;
                        if (AUTO_INC) ptr_next = ptr_inc;
                    end
                end
                RDATA: begin
                    // Advance the pointer as soon as a byte is out, giving RD_DATA
                    // the whole ACK bit to settle before the next reload
                    if (bit_done) begin
                        bit_cnt_next = '0;
                        sda_oe_next  = 1'b0;
                        if (AUTO_INC) ptr_next = ptr_inc;
                    end else begin
                        sda_oe_next = ~tx_reg[6];
                        tx_next     = {tx_reg[5:0], 1'b1};
                    end
                end
                RDATA_ACK: begin
                    sda_oe_next = 1'b0;
                    if (!mack_reg) begin
                        tx_next     = load_byte[6:0];
                        sda_oe_next = ~load_byte[7];
                    end
                end
                default: sda_oe_next = 1'b0;
            endcase
        end
    end

    assign SDA_OE    = sda_oe_reg;
    assign RD_ADDR   = ptr_reg;
    assign WR_EN     = wr_en_reg;
    assign WR_ADDR   = wr_addr_reg;
    assign WR_DATA   = wr_data_reg;
    assign BUSY      = busy_reg;
    assign XFER_DONE = done_reg;

endmodule

// File: tb/tb_i2c_slave_regport.sv
// Bit-banged I2C master driving i2c_slave_regport against a register-bank model,
// with a directed vector table, a mid-read reset sequence and randomized transactions.
module tb_i2c_slave_regport;

    localparam int Q = 6;   // system clocks per quarter SCL period

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       m_sda;
    logic       sda_oe, wr_en, busy, xfer_done;
    logic [7:0] rd_addr, rd_data, wr_addr, wr_data;
    logic       sda_line;
    logic [7:0] bank [256];

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int oe_cnt = 0;
    logic [15:0] wr_log [$];

    logic [7:0] mmem [256];
    logic [7:0] mptr;

    always #5 clk = ~clk;

    assign sda_line = m_sda & ~sda_oe;
    assign rd_data  = bank[rd_addr];

    i2c_slave_regport dut (
        .SYSTEM_CLK(clk),
        .RESET(rst),
        .SCL(scl),
        .SDA_IN(sda_line),
        .SDA_OE(sda_oe),
        .RD_ADDR(rd_addr),
        .RD_DATA(rd_data),
        .WR_EN(wr_en),
        .WR_ADDR(wr_addr),
        .WR_DATA(wr_data),
        .BUSY(busy),
        .XFER_DONE(xfer_done)
    );

    // Register bank and event counters
    initial begin
        for (int i = 0; i < 256; i++) bank[i] = 8'(8'h50 + i);
        forever begin
            @(negedge clk);
            if (wr_en) begin
                wr_log.push_back({wr_addr, wr_data});
                bank[wr_addr] = wr_data;
            end
            if (xfer_done) done_cnt++;
            if (busy) busy_cnt++;
            if (sda_oe) oe_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; q();
        scl   = 1'b1; q();
        m_sda = 1'b0; q();
        scl   = 1'b0; q();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; q();
        scl   = 1'b1; q();
        m_sda = 1'b1; q();
        q();
    endtask

    task automatic clk_bit(input bit b, output bit s);
        m_sda = b; q();
        scl   = 1'b1; q();
        s     = sda_line; q();
        scl   = 1'b0; q();
    endtask

    task automatic write_byte(input logic [7:0] b, output bit ack);
        bit s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input bit mack, output logic [7:0] d);
        bit s;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            clk_bit(1'b1, s);
            d = {d[6:0], s};
        end
        clk_bit(~mack, s);
        m_sda = 1'b1;
    endtask

    task automatic do_txn(input bit rd, input logic [6:0] addr, input int n,
                          input logic [31:0] wb, input bit stop,
                          output logic [4:0] acks, output logic [31:0] rb);
        bit a;
        logic [7:0] d;
        acks = '0;
        rb   = '0;
        i2c_start();
        write_byte({addr, rd}, a);
        acks[0] = a;
        for (int k = 0; k < n; k++) begin
            if (rd) begin
                read_byte(k != n - 1, d);
                rb[31-8*k -: 8] = d;
            end else begin
                write_byte(wb[31-8*k -: 8], a);
                acks[k+1] = a;
            end
        end
        if (stop) i2c_stop();
    endtask

    function automatic logic [7:0] sat_inc(input logic [7:0] p);
        return (p == 8'hFF) ? p : p + 8'd1;
    endfunction

    // Transaction-level reference: what the target should do with a whole message
    task automatic model_txn(input bit rd, input logic [6:0] addr, input int n,
                             input logic [31:0] wb, output logic [4:0] acks,
                             output logic [31:0] rb, output int nwr, output logic [31:0] wrs);
        bit dead;
        logic [7:0] b;
        acks = '0; rb = '0; nwr = 0; wrs = '0; dead = 1'b0;
        if (addr != 7'h23) begin
            if (rd) for (int k = 0; k < n; k++) rb[31-8*k -: 8] = 8'hFF;
        end else begin
            acks[0] = 1'b1;
            for (int k = 0; k < n; k++) begin
                if (rd) begin
                    rb[31-8*k -: 8] = (mptr < 8'd16) ? mmem[mptr] : 8'hFF;
                    mptr = sat_inc(mptr);
                end else if (!dead) begin
                    b = wb[31-8*k -: 8];
                    if (k == 0) begin
                        if (b < 8'd16) begin acks[1] = 1'b1; mptr = b; end
                        else dead = 1'b1;
                    end else if (mptr < 8'd16) begin
                        acks[k+1] = 1'b1;
                        mmem[mptr] = b;
                        wrs[31-16*nwr -: 16] = {mptr, b};
                        nwr++;
                        mptr = sat_inc(mptr);
                    end else begin
                        dead = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic run_and_check(input string tag, input bit rd, input logic [6:0] addr,
                                 input int n, input logic [31:0] tx, input bit stop,
                                 input logic [4:0] exp_ack, input logic [31:0] exp_rd,
                                 input int exp_nwr, input logic [31:0] exp_wr,
                                 input int exp_done, input int exp_ptr, input bit exp_busy);
        int d0, b0, o0, w0, nwr;
        logic [4:0] acks, mask;
        logic [31:0] rb;
        d0 = done_cnt; b0 = busy_cnt; o0 = oe_cnt; w0 = wr_log.size();
        do_txn(rd, addr, n, tx, stop, acks, rb);
        repeat (4) @(negedge clk);
        mask = '0;
        if (rd) mask[0] = 1'b1;
        else for (int k = 0; k <= n; k++) mask[k] = 1'b1;
        check({tag, "_ack"}, 32'(acks & mask), 32'(exp_ack & mask));
        if (rd) check({tag, "_rdata"}, rb, exp_rd);
        nwr = wr_log.size() - w0;
        check({tag, "_nwr"}, 32'(nwr), 32'(exp_nwr));
        for (int j = 0; j < exp_nwr && j < nwr; j++)
            check({tag, "_wr"}, 32'(wr_log[w0+j]), 32'(exp_wr[31-16*j -: 16]));
        check({tag, "_done"}, 32'(done_cnt - d0), 32'(exp_done));
        if (stop) check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_busy_seen"}, 32'(busy_cnt != b0), 32'(exp_busy));
        if (!exp_busy) check({tag, "_oe_seen"}, 32'(oe_cnt != o0), 32'd0);
        if (exp_ptr >= 0) check({tag, "_ptr"}, 32'(rd_addr), 32'(exp_ptr));
        $display("txn %s: %s addr=%02h n=%0d acks=%b rdata=%08h writes=%0d",
                 tag, rd ? "rd" : "wr", addr, n, acks & mask, rb, nwr);
    endtask

    typedef struct {
        bit          rd;
        logic [6:0]  addr;
        int          n;
        logic [31:0] tx;
        bit          stop;
        logic [4:0]  exp_ack;
        logic [31:0] exp_rd;
        int          exp_nwr;
        logic [31:0] exp_wr;
        int          exp_done;
        int          exp_ptr;
        bit          exp_busy;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [4:0]  m_ack;
        logic [31:0] m_rb, m_wrs, tx;
        int          m_nwr, n, t_wait;
        bit          a, s, rd;
        logic [2:0]  bits;
        logic [6:0]  addr;

        tbl[0] = '{rd:1'b0, addr:7'h23, n:3, tx:32'h02A53C00, stop:1'b1, exp_ack:5'b01111,
                   exp_rd:32'h0, exp_nwr:2, exp_wr:32'h02A5033C, exp_done:1, exp_ptr:8'h04, exp_busy:1'b1};
        tbl[1] = '{rd:1'b0, addr:7'h23, n:1, tx:32'h05000000, stop:1'b0, exp_ack:5'b00011,
                   exp_rd:32'h0, exp_nwr:0, exp_wr:32'h0, exp_done:0, exp_ptr:8'h05, exp_busy:1'b1};
        tbl[2] = '{rd:1'b1, addr:7'h23, n:3, tx:32'h0, stop:1'b1, exp_ack:5'b00001,
                   exp_rd:32'h55565700, exp_nwr:0, exp_wr:32'h0, exp_done:1, exp_ptr:8'h08, exp_busy:1'b1};
        tbl[3] = '{rd:1'b0, addr:7'h24, n:2, tx:32'h01770000, stop:1'b1, exp_ack:5'b00000,
                   exp_rd:32'h0, exp_nwr:0, exp_wr:32'h0, exp_done:0, exp_ptr:8'h08, exp_busy:1'b0};
        tbl[4] = '{rd:1'b0, addr:7'h23, n:1, tx:32'h0F000000, stop:1'b1, exp_ack:5'b00011,
                   exp_rd:32'h0, exp_nwr:0, exp_wr:32'h0, exp_done:1, exp_ptr:8'h0F, exp_busy:1'b1};
        tbl[5] = '{rd:1'b1, addr:7'h23, n:2, tx:32'h0, stop:1'b1, exp_ack:5'b00001,
                   exp_rd:32'h5FFF0000, exp_nwr:0, exp_wr:32'h0, exp_done:1, exp_ptr:-1, exp_busy:1'b1};
        tbl[6] = '{rd:1'b0, addr:7'h23, n:2, tx:32'h10990000, stop:1'b1, exp_ack:5'b00001,
                   exp_rd:32'h0, exp_nwr:0, exp_wr:32'h0, exp_done:1, exp_ptr:-1, exp_busy:1'b1};
        tbl[7] = '{rd:1'b0, addr:7'h23, n:3, tx:32'h0F112200, stop:1'b1, exp_ack:5'b00111,
                   exp_rd:32'h0, exp_nwr:1, exp_wr:32'h0F110000, exp_done:1, exp_ptr:8'h10, exp_busy:1'b1};

        for (int i = 0; i < 256; i++) mmem[i] = 8'(8'h50 + i);
        mptr  = 8'h00;
        rst   = 1'b1;
        scl   = 1'b1;
        m_sda = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_sda_oe", 32'(sda_oe), 32'd0);
        check("reset_wr_en", 32'(wr_en), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_xfer_done", 32'(xfer_done), 32'd0);
        check("reset_ptr", 32'(rd_addr), 32'd0);
        check("reset_wr_addr", 32'(wr_addr), 32'd0);
        check("reset_wr_data", 32'(wr_data), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            model_txn(tbl[i].rd, tbl[i].addr, tbl[i].n, tbl[i].tx, m_ack, m_rb, m_nwr, m_wrs);
            run_and_check($sformatf("v%0d", i), tbl[i].rd, tbl[i].addr, tbl[i].n, tbl[i].tx,
                          tbl[i].stop, tbl[i].exp_ack, tbl[i].exp_rd, tbl[i].exp_nwr,
                          tbl[i].exp_wr, tbl[i].exp_done, tbl[i].exp_ptr, tbl[i].exp_busy);
        end

        // Reset while the target drives a 0 data bit during a read of 8'hA5 at pointer 0x02
        model_txn(1'b0, 7'h23, 1, 32'h02000000, m_ack, m_rb, m_nwr, m_wrs);
        run_and_check("rst_pre", 1'b0, 7'h23, 1, 32'h02000000, 1'b1, 5'b00011, 32'h0,
                      0, 32'h0, 1, 8'h02, 1'b1);
        i2c_start();
        write_byte({7'h23, 1'b1}, a);
        check("rst_read_addr_ack", 32'(a), 32'd1);
        bits = '0;
        for (int k = 0; k < 3; k++) begin
            clk_bit(1'b1, s);
            bits = {bits[1:0], s};
        end
        check("rst_read_first_bits", 32'(bits), 32'b101);
        t_wait = 0;
        while (!sda_oe && t_wait < 20) begin
            @(negedge clk);
            t_wait++;
        end
        check("rst_oe_before", 32'(sda_oe), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_oe_after", 32'(sda_oe), 32'd0);
        check("rst_busy_after", 32'(busy), 32'd0);
        check("rst_ptr_after", 32'(rd_addr), 32'd0);
        rst = 1'b0;
        mptr = 8'h00;
        repeat (3) @(negedge clk);
        model_txn(1'b0, 7'h23, 1, 32'h01000000, m_ack, m_rb, m_nwr, m_wrs);
        run_and_check("rst_post", 1'b0, 7'h23, 1, 32'h01000000, 1'b1, 5'b00011, 32'h0,
                      0, 32'h0, 1, 8'h01, 1'b1);

        for (int t = 0; t < 20; t++) begin
            rd   = ($urandom_range(0, 2) == 0);
            addr = ($urandom_range(0, 5) == 0) ? 7'h24 : 7'h23;
            n    = $urandom_range(1, 3);
            tx   = $urandom;
            if (!rd) tx[31:24] = 8'($urandom_range(0, 19));
            model_txn(rd, addr, n, tx, m_ack, m_rb, m_nwr, m_wrs);
            run_and_check($sformatf("r%0d", t), rd, addr, n, tx, 1'b1, m_ack, m_rb,
                          m_nwr, m_wrs, (addr == 7'h23) ? 1 : 0, int'(mptr), addr == 7'h23);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
